// File: rtl/config_ram_arbiter.sv
// rtl/config_ram_arbiter.sv - round-robin two-port arbiter/sequencer for the config RAM
// Serialises bus-side and loader accesses; watchdog aborts accesses stuck on ram_busy.
module config_ram_arbiter #(
    parameter int N_BYTES   = 4,
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = $clog2(DEPTH),
    parameter int N_BITS    = N_BYTES * 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 we0,
    input  logic                 we1,
    input  logic [ADDR_BITS-1:0] addr0,
    input  logic [ADDR_BITS-1:0] addr1,
    input  logic [N_BITS-1:0]    wdata0,
    input  logic [N_BITS-1:0]    wdata1,
    input  logic [N_BYTES-1:0]   be0,
    input  logic [N_BYTES-1:0]   be1,
    output logic                 done0,
    output logic                 done1,
    output logic [N_BITS-1:0]    rdata0,
    output logic [N_BITS-1:0]    rdata1,
    output logic                 err0,
    output logic                 err1,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [N_BITS-1:0]    ram_wdata,
    output logic [N_BYTES-1:0]   ram_byte_en,
    output logic                 ram_wen,
    output logic                 ram_ren,
    input  logic [N_BITS-1:0]    ram_rdata,
    input  logic                 ram_busy
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                 state, next_state;
    logic                   last_grant;
    logic                   id;
    logic                   lat_we;
    logic [ADDR_BITS-1:0]   lat_addr;
    logic [N_BITS-1:0]      lat_wdata;
    logic [N_BYTES-1:0]     lat_be;
    logic [CW-1:0]          counter;
    logic                   grant;
    logic                   grant_id;
    logic                   timed_out;

    assign ram_addr    = lat_addr;
    assign ram_wdata   = lat_wdata;
    assign ram_byte_en = lat_be;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        grant_id   = 1'b0;
        timed_out  = 1'b0;
        ram_wen    = 1'b0;
        ram_ren    = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant      = 1'b1;
                    // On contention the port that did not win last time goes next
                    grant_id   = (req0 && req1) ? ~last_grant : req1;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                ram_wen   = lat_we;
                ram_ren   = ~lat_we;
                timed_out = (TIMEOUT != 0) && ram_busy && (counter == CW'(TIMEOUT - 1));
                if (!ram_busy || timed_out) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                done0      = ~id;
                done1      = id;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_grant <= 1'b1;
            id         <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
            counter    <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
            err0       <= 1'b0;
            err1       <= 1'b0;
        end else begin
            if (grant) begin
                id         <= grant_id;
                last_grant <= grant_id;
                lat_we     <= grant_id ? we1 : we0;
                lat_addr   <= grant_id ? addr1 : addr0;
                lat_wdata  <= grant_id ? wdata1 : wdata0;
                lat_be     <= grant_id ? be1 : be0;
                counter    <= '0;
            end
            if (state == ACCESS) begin
                if (!ram_busy) begin
                    if (id) begin
                        rdata1 <= lat_we ? '0 : ram_rdata;
                        err1   <= 1'b0;
                    end else begin
                        rdata0 <= lat_we ? '0 : ram_rdata;
                        err0   <= 1'b0;
                    end
                end else if (timed_out) begin
                    if (id) begin
                        rdata1 <= '0;
                        err1   <= 1'b1;
                    end else begin
                        rdata0 <= '0;
                        err0   <= 1'b1;
                    end
                end else begin
                    counter <= counter + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_config_ram_arbiter.sv
// tb/tb_config_ram_arbiter.sv - bench for config_ram_arbiter
// Transaction-level model predicts grant order, access duration and results per request.
module tb_config_ram_arbiter;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          busy;
    } txn_t;

    typedef struct {
        int          port;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          busy;
        logic [31:0] xr;
        logic        xe;
        int          xs;
    } vec_t;

    logic        CLK, nRST;
    logic        req[2], we[2], done[2], err[2];
    logic [7:0]  addr[2];
    logic [31:0] wdata[2], rdata[2];
    logic [3:0]  be[2];
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_byte_en;
    logic        ram_wen, ram_ren, ram_busy;
    logic [31:0] ram[256];

    assign ram_rdata = ram[ram_addr];

    config_ram_arbiter #(.N_BYTES(4), .DEPTH(256), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST),
        .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
        .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
        .be0(be[0]), .be1(be[1]), .done0(done[0]), .done1(done[1]),
        .rdata0(rdata[0]), .rdata1(rdata[1]), .err0(err[0]), .err1(err[1]),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_byte_en(ram_byte_en),
        .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_rdata(ram_rdata), .ram_busy(ram_busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          free_at = 0;
    bit          active = 0;
    int          srv, g_cyc, d_cyc, last_g, n_strobe;
    txn_t        cur;
    txn_t        q[2][$];
    logic [31:0] ref_mem[256];
    logic [31:0] exp_rd[2];
    logic [31:0] res_rd;
    logic        res_err;
    logic [31:0] got_rd[2];
    logic        got_err[2];
    int          got_strobes[2];
    int          order[$];
    int          done_cyc[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] b);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        active = 0;
        last_g = 1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        q[0].delete();
        q[1].delete();
    endtask

    // Predict a service once the model sees the arbiter free with a request pending
    task automatic sample();
        logic acc;
        int   p, alen;
        if (ram_wen && !ram_busy) ram[ram_addr] = merge(ram[ram_addr], ram_wdata, ram_byte_en);
        acc = active && cyc > g_cyc && cyc < d_cyc;
        chk("ram_wen", ram_wen, acc && cur.we);
        chk("ram_ren", ram_ren, acc && !cur.we);
        if (acc) begin
            n_strobe++;
            chk("ram_addr", ram_addr, cur.addr);
            if (cur.we) begin
                chk("ram_wdata", ram_wdata, cur.wdata);
                chk("ram_byte_en", ram_byte_en, cur.be);
            end
        end
        if (active && cyc == d_cyc) exp_rd[srv] = res_rd;
        chk("one_done", done[0] && done[1], 0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("done%0d", k), done[k], active && cyc == d_cyc && srv == k);
            chk($sformatf("rdata%0d", k), rdata[k], exp_rd[k]);
            if (active && cyc == d_cyc && srv == k) chk($sformatf("err%0d", k), err[k], res_err);
        end
        if (active && cyc == d_cyc) begin
            got_rd[srv] = rdata[srv];
            got_err[srv] = err[srv];
            got_strobes[srv] = n_strobe;
            order.push_back(srv);
            done_cyc.push_back(cyc);
            void'(q[srv].pop_front());
            active = 0;
            free_at = cyc + 1;
        end
        if (!active && cyc >= free_at && (req[0] || req[1])) begin
            p = (req[0] && req[1]) ? 1 - last_g : (req[1] ? 1 : 0);
            last_g = p;
            srv = p;
            cur = q[p][0];
            g_cyc = cyc;
            n_strobe = 0;
            alen = (cur.busy >= TIMEOUT) ? TIMEOUT : cur.busy + 1;
            d_cyc = cyc + alen + 1;
            active = 1;
            if (cur.busy >= TIMEOUT) begin
                res_rd = '0;
                res_err = 1'b1;
            end else if (cur.we) begin
                ref_mem[cur.addr] = merge(ref_mem[cur.addr], cur.wdata, cur.be);
                res_rd = '0;
                res_err = 1'b0;
            end else begin
                res_rd = ref_mem[cur.addr];
                res_err = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        for (int p = 0; p < 2; p++) begin
            if (active && srv == p && cyc > g_cyc && cyc < d_cyc) begin
                // Served port scribbles on its request lines; the access must not notice
                req[p] = 1'($urandom_range(0, 1));
                we[p] = 1'($urandom);
                addr[p] = 8'($urandom);
                wdata[p] = $urandom;
                be[p] = 4'($urandom);
            end else if (q[p].size() != 0) begin
                req[p] = 1'b1;
                we[p] = q[p][0].we;
                addr[p] = q[p][0].addr;
                wdata[p] = q[p][0].wdata;
                be[p] = q[p][0].be;
            end else begin
                req[p] = 1'b0;
            end
        end
        ram_busy = active && cyc > g_cyc && cyc < d_cyc && (cyc - g_cyc) <= cur.busy;
        @(negedge CLK);
        sample();
    endtask

    task automatic run(int budget);
        int n = 0;
        while ((active || q[0].size() != 0 || q[1].size() != 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (active || q[0].size() != 0 || q[1].size() != 0) begin
            errors++;
            $display("FAIL run_budget: still pending after %0d cycles, required idle", budget);
        end
    endtask

    task automatic push(int p, logic w, logic [7:0] a, logic [31:0] d, logic [3:0] b, int bz);
        txn_t t;
        t.we = w; t.addr = a; t.wdata = d; t.be = b; t.busy = bz;
        q[p].push_back(t);
    endtask

    vec_t vt[7];
    int   exp_order[4];
    int   waited;

    initial begin
        vt[0] = '{0, 1'b0, 8'h10, 32'h0,        4'h0, 0,   32'hDEADBEEF, 1'b0, 1};
        vt[1] = '{1, 1'b1, 8'h20, 32'hAABBCCDD, 4'h5, 0,   32'h0,        1'b0, 1};
        vt[2] = '{0, 1'b0, 8'h20, 32'h0,        4'h0, 0,   32'h11BB33DD, 1'b0, 1};
        vt[3] = '{1, 1'b0, 8'h10, 32'h0,        4'h0, 5,   32'hDEADBEEF, 1'b0, 6};
        vt[4] = '{0, 1'b0, 8'h10, 32'h0,        4'h0, 100, 32'h0,        1'b1, 16};
        vt[5] = '{0, 1'b1, 8'h30, 32'h12345678, 4'hF, 2,   32'h0,        1'b0, 3};
        vt[6] = '{1, 1'b0, 8'h30, 32'h0,        4'h0, 0,   32'h12345678, 1'b0, 1};
        exp_order = '{0, 1, 0, 1};

        for (int i = 0; i < 256; i++) begin
            ram[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        ram[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
        ram[8'h20] = 32'h11223344; ref_mem[8'h20] = 32'h11223344;

        nRST = 1'b0;
        ram_busy = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 0; we[p] = 0; addr[p] = 0; wdata[p] = 0; be[p] = 0;
        end
        model_reset();
        repeat (2) @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            chk("reset_done", done[k], 0);
            chk("reset_rdata", rdata[k], 0);
            chk("reset_err", err[k], 0);
        end
        chk("reset_wen", ram_wen, 0);
        chk("reset_ren", ram_ren, 0);
        chk("reset_addr", ram_addr, 0);
        chk("reset_wdata", ram_wdata, 0);
        chk("reset_be", ram_byte_en, 0);
        nRST = 1'b1;

        for (int i = 0; i < 7; i++) begin
            push(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, vt[i].busy);
            run(60);
            chk($sformatf("vec%0d_rdata", i), got_rd[vt[i].port], vt[i].xr);
            chk($sformatf("vec%0d_err", i), got_err[vt[i].port], vt[i].xe);
            chk($sformatf("vec%0d_strobes", i), got_strobes[vt[i].port], vt[i].xs);
        end

        for (int i = 0; i < 48; i++) begin
            push($urandom_range(0, 1), 1'($urandom), 8'($urandom_range(0, 15)), $urandom,
                 4'($urandom), ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3));
        end
        run(3000);

        push(0, 1'b0, 8'h10, 32'h0, 4'h0, 10);
        waited = 0;
        while (!ram_ren && waited < 6) begin
            step();
            waited++;
        end
        chk("rst_mid_reached_access", ram_ren, 1);
        @(posedge CLK);
        #1;
        cyc++;
        nRST = 1'b0;
        #1;
        chk("rst_mid_ren", ram_ren, 0);
        chk("rst_mid_wen", ram_wen, 0);
        chk("rst_mid_done0", done[0], 0);
        chk("rst_mid_done1", done[1], 0);
        chk("rst_mid_rdata0", rdata[0], 0);
        model_reset();
        req[0] = 0;
        req[1] = 0;
        ram_busy = 0;
        @(negedge CLK);
        nRST = 1'b1;
        free_at = cyc + 1;

        order.delete();
        done_cyc.delete();
        push(0, 1'b0, 8'h10, 32'h0, 4'h0, 0);
        push(1, 1'b0, 8'h20, 32'h0, 4'h0, 0);
        push(0, 1'b0, 8'h30, 32'h0, 4'h0, 0);
        push(1, 1'b0, 8'h05, 32'h0, 4'h0, 0);
        run(100);
        chk("contend_count", order.size(), 4);
        for (int i = 0; i < order.size() && i < 4; i++) begin
            chk($sformatf("contend_order%0d", i), order[i], exp_order[i]);
            if (i > 0) chk($sformatf("contend_gap%0d", i), done_cyc[i] - done_cyc[i-1], 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
